// File: rtl/dmem_pkg.sv
// +----------------------------------------------------------------------+
// | dmem_pkg: shared types and sizing helpers for the data memory LSU    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package dmem_pkg;

  typedef enum logic [2:0] {
    SZ_B  = 3'b000,
    SZ_H  = 3'b001,
    SZ_W  = 3'b010,
    SZ_BU = 3'b100,
    SZ_HU = 3'b101
  } mem_size_e;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } lsu_state_e;

  function automatic logic size_legal(input logic [2:0] size);
    logic ok;
    case (size)
      SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU: ok = 1'b1;
      default:                        ok = 1'b0;
    endcase
    return ok;
  endfunction

  // True when the access spills past byte 3 of its word.
  function automatic logic crosses_word(input logic [2:0] size, input logic [1:0] lane);
    return ((size[1:0] == 2'b01) && (lane == 2'd3)) ||
           ((size[1:0] == 2'b10) && (lane != 2'd0));
  endfunction

  // Byte enables over a two-word window: [3:0] first word, [7:4] next word.
  function automatic logic [7:0] be_gen(input logic [2:0] size, input logic [1:0] lane);
    logic [7:0] mask;
    case (size[1:0])
      2'b00:   mask = 8'h01;
      2'b01:   mask = 8'h03;
      default: mask = 8'h0F;
    endcase
    return mask << lane;
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] size, input logic [31:0] raw);
    logic [31:0] res;
    case (size)
      SZ_B:    res = {{24{raw[7]}}, raw[7:0]};
      SZ_H:    res = {{16{raw[15]}}, raw[15:0]};
      SZ_BU:   res = {24'b0, raw[7:0]};
      SZ_HU:   res = {16'b0, raw[15:0]};
      default: res = raw;
    endcase
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_bank.sv
// +----------------------------------------------------------------------+
// | dmem_bank: word RAM with byte enables and read-first registered read |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module dmem_bank #(
  parameter int DEPTH_WORDS = 512,
  parameter int IW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    be,
  input  logic [IW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // The read samples the array before this edge's write lands.
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[addr];
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/data_memory_lsu.sv
// +----------------------------------------------------------------------+
// | data_memory_lsu: RV32 load/store unit over a byte-addressable RAM    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module data_memory_lsu
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 512,
  parameter int SPLIT_MISAL = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault
);

  localparam int            IW       = $clog2(DEPTH_WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH_WORDS - 1);

  lsu_state_e state, state_nxt;

  logic [IW-1:0] w_idx;
  logic [1:0]    w_lane;
  logic          w_upper_nz;
  logic          w_cross;
  logic          w_fault;
  logic [7:0]    w_be;
  logic [63:0]   w_wdata_sh;
  logic          w_accept;
  logic          w_go_split;
  logic          w_rsp_next;
  logic          w_bank_en;
  logic [3:0]    w_bank_be;
  logic [IW-1:0] w_bank_addr;
  logic [31:0]   w_bank_wdata;
  logic [31:0]   w_bank_rdata;
  logic [63:0]   w_load_win;

  logic          r_rsp_valid;
  logic          r_rsp_fault;
  logic          r_rsp_load;
  logic          r_split;
  logic [2:0]    r_size;
  logic [1:0]    r_lane;
  logic          r_we;
  logic [IW-1:0] r_idx_hi;
  logic [3:0]    r_be_hi;
  logic [31:0]   r_wdata_hi;
  logic [31:0]   r_lo_word;

  assign w_idx      = req_addr[2 +: IW];
  assign w_lane     = req_addr[1:0];
  assign w_upper_nz = (req_addr >> (IW + 2)) != '0;
  assign w_cross    = crosses_word(req_size, w_lane);
  assign w_be       = be_gen(req_size, w_lane);
  assign w_wdata_sh = {32'b0, req_wdata} << {w_lane, 3'b000};

  // A crossing access faults when splitting is disabled or its second word would not exist.
  assign w_fault = !size_legal(req_size) || w_upper_nz ||
                   (w_cross && ((SPLIT_MISAL == 0) || (w_idx == LAST_IDX)));

  always_comb begin
    state_nxt    = state;
    req_ready    = 1'b0;
    w_accept     = 1'b0;
    w_go_split   = 1'b0;
    w_rsp_next   = 1'b0;
    w_bank_en    = 1'b0;
    w_bank_be    = 4'b0;
    w_bank_addr  = w_idx;
    w_bank_wdata = w_wdata_sh[31:0];
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        w_accept  = req_valid;
        if (req_valid) begin
          if (!w_fault) begin
            w_bank_en = 1'b1;
            w_bank_be = req_we ? w_be[3:0] : 4'b0;
          end
          if (!w_fault && w_cross) begin
            w_go_split = 1'b1;
            state_nxt  = SPLIT;
          end else begin
            w_rsp_next = 1'b1;
          end
        end
      end
      SPLIT: begin
        w_bank_en    = 1'b1;
        w_bank_addr  = r_idx_hi;
        w_bank_be    = r_we ? r_be_hi : 4'b0;
        w_bank_wdata = r_wdata_hi;
        w_rsp_next   = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_fault <= 1'b0;
      r_rsp_load  <= 1'b0;
      r_split     <= 1'b0;
      r_size      <= 3'b0;
      r_lane      <= 2'b0;
      r_we        <= 1'b0;
      r_idx_hi    <= '0;
      r_be_hi     <= 4'b0;
      r_wdata_hi  <= 32'b0;
      r_lo_word   <= 32'b0;
    end else begin
      r_rsp_valid <= w_rsp_next;
      if (w_accept) begin
        r_rsp_fault <= w_fault;
        r_rsp_load  <= !req_we && !w_fault;
        r_split     <= w_go_split;
        r_size      <= req_size;
        r_lane      <= w_lane;
        r_we        <= req_we;
        r_idx_hi    <= w_idx + IW'(1);
        r_be_hi     <= w_be[7:4];
        r_wdata_hi  <= w_wdata_sh[63:32];
      end
      if (state == SPLIT) begin
        r_lo_word <= w_bank_rdata;
      end
    end
  end

  dmem_bank #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IW          (IW)
  ) u_bank (
    .clk   (clk),
    .en    (w_bank_en),
    .be    (w_bank_be),
    .addr  (w_bank_addr),
    .wdata (w_bank_wdata),
    .rdata (w_bank_rdata)
  );

  // Split loads see {second word, first word}; lane shift brings the addressed byte to bit 0.
  assign w_load_win = (r_split ? {w_bank_rdata, r_lo_word} : {32'b0, w_bank_rdata})
                      >> {r_lane, 3'b000};

  assign rsp_valid = r_rsp_valid;
  assign rsp_fault = r_rsp_valid && r_rsp_fault;
  assign rsp_rdata = (r_rsp_valid && r_rsp_load) ? load_ext(r_size, w_load_win[31:0]) : 32'b0;

endmodule

`default_nettype wire

// File: tb/tb_data_memory_lsu.sv
// Scoreboarded random and directed bench for data_memory_lsu against a byte-array model.
`default_nettype none

module tb_data_memory_lsu;

  localparam int BYTES = 2048;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_fault;
  logic [31:0] rsp_rdata;
  logic        f_req_valid, f_req_ready, f_rsp_valid, f_rsp_fault;
  logic [31:0] f_rsp_rdata;

  always #5 clk = ~clk;

  data_memory_lsu #(.ADDR_W(32), .DEPTH_WORDS(512), .SPLIT_MISAL(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault));

  data_memory_lsu #(.ADDR_W(32), .DEPTH_WORDS(512), .SPLIT_MISAL(0)) dut_f (
    .clk(clk), .rst_n(rst_n), .req_valid(f_req_valid), .req_ready(f_req_ready),
    .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(f_rsp_valid), .rsp_rdata(f_rsp_rdata), .rsp_fault(f_rsp_fault));

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          due;
    logic [31:0] addr;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  logic [7:0]  model_mem [BYTES];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain byte-array semantics of RV32 loads/stores with the fault rules.
  function automatic void model(input bit we, input logic [2:0] size, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic [31:0] rd,
                                output bit fault, output bit split);
    int n;
    longint a;
    logic [31:0] v;
    rd = 32'b0; fault = 1'b0; split = 1'b0;
    a = longint'(addr);
    if (!(size inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) begin
      fault = 1'b1;
      return;
    end
    n = (size[1:0] == 2'b00) ? 1 : (size[1:0] == 2'b01) ? 2 : 4;
    if (a + n > BYTES) begin
      fault = 1'b1;
      return;
    end
    split = ((a % 4) + n) > 4;
    if (we) begin
      for (int i = 0; i < n; i++) model_mem[a + i] = wdata[8*i +: 8];
    end else begin
      v = 32'b0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = model_mem[a + i];
      if (!size[2] && n < 4 && v[8*n-1]) begin
        for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
      end
      rd = v;
    end
  endfunction

  task automatic issue(input bit we, input logic [2:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit push, output int waits);
    logic [31:0] rd;
    bit f, sp;
    int guard;
    req_valid = 1'b1; req_we = we; req_size = size; req_addr = addr; req_wdata = wdata;
    waits = 0;
    for (guard = 0; guard < 20; guard++) begin
      @(negedge clk);
      if (req_ready) break;
      waits++;
    end
    if (guard == 20) begin
      checks++; failures++;
      $display("FAIL accept_timeout addr=%08h ready=%0b required ready=1", addr, req_ready);
    end
    model(we, size, addr, wdata, rd, f, sp);
    if (push) sbq.push_back('{rd, f, cyc + ((sp && !f) ? 2 : 1), addr});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    req_valid = 1'b0;
    for (int i = 0; i < 50 && sbq.size() > 0; i++) @(posedge clk);
    #1;
    if (sbq.size() > 0) begin
      checks++; failures++;
      $display("FAIL drain pending=%0d required 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%08h required=%08h", name, act, req);
    end
  endtask

  task automatic f_access(input bit we, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rd,
                          input logic exp_f, input string name);
    req_we = we; req_size = size; req_addr = addr; req_wdata = wdata;
    f_req_valid = 1'b1;
    @(negedge clk);
    check_val({name, "_ready"}, {31'b0, f_req_ready}, 32'd1);
    @(posedge clk);
    #1;
    f_req_valid = 1'b0;
    @(negedge clk);
    check_val({name, "_valid"}, {31'b0, f_rsp_valid}, 32'd1);
    check_val({name, "_rdata"}, f_rsp_rdata, exp_rd);
    check_val({name, "_fault"}, {31'b0, f_rsp_fault}, {31'b0, exp_f});
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a response.
  always @(negedge clk) begin
    if (rst_n) begin
      while (sbq.size() > 0 && sbq[0].due < cyc) begin
        checks++; failures++;
        $display("FAIL missing_rsp addr=%08h due=%0d now=%0d", sbq[0].addr, sbq[0].due, cyc);
        void'(sbq.pop_front());
      end
      if (rsp_valid) begin
        checks++;
        if (sbq.size() == 0) begin
          failures++;
          $display("FAIL unexpected_rsp rdata=%08h fault=%0b required no response", rsp_rdata, rsp_fault);
        end else begin
          mon_e = sbq.pop_front();
          if (rsp_rdata !== mon_e.rdata || rsp_fault !== mon_e.fault || cyc != mon_e.due) begin
            failures++;
            $display("FAIL rsp addr=%08h rdata=%08h fault=%0b cyc=%0d required rdata=%08h fault=%0b cyc=%0d",
                     mon_e.addr, rsp_rdata, rsp_fault, cyc, mon_e.rdata, mon_e.fault, mon_e.due);
          end
        end
      end
    end
  end

  logic [2:0] sz_tab [12] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd2, 3'd4, 3'd3, 3'd7};

  initial begin
    int          w, wsum;
    logic [7:0]  old30, old31;
    logic [31:0] a;
    int          r;

    req_valid = 1'b0; f_req_valid = 1'b0; req_we = 1'b0;
    req_size = 3'b010; req_addr = 32'b0; req_wdata = 32'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_ready", {31'b0, req_ready}, 32'd1);
    check_val("reset_valid", {31'b0, rsp_valid}, 32'd0);
    check_val("reset_rdata", rsp_rdata, 32'd0);
    check_val("reset_fault", {31'b0, rsp_fault}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 32; i++) issue(1'b1, 3'b010, i * 4, $urandom, 1'b1, w);
    for (int i = 508; i < 512; i++) issue(1'b1, 3'b010, i * 4, $urandom, 1'b1, w);
    idle(2);

    issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b1, w);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, w);
    issue(1'b1, 3'b000, 32'h11, 32'h00000080, 1'b1, w);
    issue(1'b0, 3'b000, 32'h11, 32'h0, 1'b1, w);
    issue(1'b0, 3'b100, 32'h11, 32'h0, 1'b1, w);
    issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, w);
    idle(1);

    issue(1'b1, 3'b010, 32'h1E, 32'h11223344, 1'b1, w);
    issue(1'b0, 3'b010, 32'h1E, 32'h0, 1'b1, w);
    check_val("split_ready_stall", w, 32'd1);
    issue(1'b0, 3'b101, 32'h1C, 32'h0, 1'b1, w);
    issue(1'b0, 3'b001, 32'h1F, 32'h0, 1'b1, w);
    idle(1);

    wsum = 0;
    for (int i = 0; i < 8; i++) begin
      issue((i % 2) == 0, 3'b010, 32'h40 + (i / 2) * 4, $urandom, 1'b1, w);
      wsum += w;
    end
    check_val("b2b_stalls", wsum, 32'd0);
    idle(1);

    issue(1'b0, 3'b010, 32'h800, 32'h0, 1'b1, w);
    issue(1'b0, 3'b010, 32'h7FE, 32'h0, 1'b1, w);
    issue(1'b1, 3'b001, 32'h7FF, 32'h5555, 1'b1, w);
    issue(1'b1, 3'b011, 32'h20, 32'h12345678, 1'b1, w);
    issue(1'b0, 3'b010, 32'h20, 32'h0, 1'b1, w);
    issue(1'b0, 3'b010, 32'h7FC, 32'h0, 1'b1, w);
    idle(1);

    for (int i = 0; i < 400; i++) begin
      r = $urandom % 10;
      if (r < 7)      a = $urandom_range(0, 32'h5F);
      else if (r < 9) a = $urandom_range(32'h7F0, 32'h7FF);
      else            a = $urandom | 32'h800;
      issue($urandom % 2, sz_tab[$urandom % 12], a, $urandom, 1'b1, w);
      if ($urandom % 4 == 0) idle($urandom_range(1, 2));
    end
    drain();

    old30 = model_mem[32'h30];
    old31 = model_mem[32'h31];
    issue(1'b1, 3'b010, 32'h2E, 32'hA1B2C3D4, 1'b0, w);
    req_valid = 1'b0;
    @(negedge clk);
    check_val("split_state_ready", {31'b0, req_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check_val("rst_split_ready", {31'b0, req_ready}, 32'd1);
    check_val("rst_split_valid", {31'b0, rsp_valid}, 32'd0);
    model_mem[32'h30] = old30;
    model_mem[32'h31] = old31;
    @(posedge clk);
    #1;
    check_val("rst_split_novalid", {31'b0, rsp_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(1'b0, 3'b010, 32'h2C, 32'h0, 1'b1, w);
    check_val("post_reset_accept", w, 32'd0);
    issue(1'b0, 3'b010, 32'h30, 32'h0, 1'b1, w);
    drain();

    f_access(1'b1, 3'b010, 32'h20, 32'hCAFEBABE, 32'h0, 1'b0, "f_sw");
    f_access(1'b0, 3'b001, 32'h23, 32'h0, 32'h0, 1'b1, "f_lh_misal");
    f_access(1'b1, 3'b010, 32'h22, 32'h12345678, 32'h0, 1'b1, "f_sw_misal");
    f_access(1'b0, 3'b010, 32'h20, 32'h0, 32'hCAFEBABE, 1'b0, "f_lw_unchanged");
    f_access(1'b0, 3'b010, 32'h800, 32'h0, 32'h0, 1'b1, "f_oor");
    f_access(1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFFCAFE, 1'b0, "f_lh_lane2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
